sdft_scheduler: RTL
===================

# sdft_scheduler

Sequencer for the sliding-DFT core. It takes a free-running sample stream and feeds it to the core one sample per update, using the core's start/ready handshake. Every `scan_divider` samples it scans all frequency bins through the core's read port and streams them out on a valid/accept interface to a downstream consumer (magnitude, display, UART). A one-entry sample buffer absorbs arrivals while the core is busy and flags overrun.

## Interface
Parameters:
- `data_width`, 8: sample width, signed.
- `freq_bins`, 16: number of bins in the core; power of two.
- `bin_width`, 23: width of the core's bin outputs, signed.
- `scan_divider`, 4: a bin scan is scheduled after every Nth accepted sample; legal range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `sample_in`  in  `data_width`  new sample, signed.
- `sample_valid`  in  1  one-cycle strobe; `sample_in` is valid this cycle.
- `overrun_clear`  in  1  clears `overrun`.
- `sdft_sample`  out  `data_width`  sample presented to the core.
- `sdft_start`  out  1  one-cycle pulse that launches an update.
- `sdft_read`  out  1  one-cycle pulse that requests a bin read.
- `sdft_bin_addr`  out  clog2(`freq_bins`)  bin being read.
- `sdft_ready`  in  1  core idle; it accepts a start or read only while this is high.
- `sdft_bin_real`, `sdft_bin_imag`  in  `bin_width`  core bin outputs.
- `bin_valid`  out  1  `bin_real`, `bin_imag` and `bin_index` are valid.
- `bin_accept`  in  1  consumer takes the bin when `bin_valid` and `bin_accept` are both high.
- `bin_index`  out  clog2(`freq_bins`)  index of the bin being presented.
- `bin_real`, `bin_imag`  out  `bin_width`  bin value.
- `scan_done`  out  1  one-cycle pulse after the last bin is accepted.
- `overrun`  out  1  sticky; a sample was dropped.
- `busy`  out  1  state is not IDLE.

## Operation
- Sample buffer: one entry plus a `full` flag.
  - `sample_valid` while not full: capture the sample and set `full`.
  - `sample_valid` while full: drop the new sample, set `overrun`, keep the held sample.
- `overrun` clears only on `overrun_clear` or reset. If `overrun_clear` and a drop occur in the same cycle, the set wins.
- States: IDLE, START, WAIT_CALC, READ, WAIT_READ, PRESENT.
- IDLE:
  - If `full` and `sdft_ready` are high, go to START. This has priority over a scan.
  - Otherwise, if a scan is pending and `sdft_ready` is high, go to READ.
- START: assert `sdft_start` for one cycle. `sdft_sample` is driven from the buffer and held stable until the WAIT_CALC exit. Clear `full` when the state is exited, so a capture in that same cycle is not lost. Increment the sample counter. When the counter reaches `scan_divider`, wrap it to 0 and set `scan_pending`. Go to WAIT_CALC.
- WAIT_CALC: ignore `sdft_ready` in the first cycle, because it can still read high from before the start. Leave when `sdft_ready` is high: go to IDLE if no scan is active, otherwise resume the scan at READ.
- READ: assert `sdft_read` for one cycle with `sdft_bin_addr` = scan index, and hold the address until the WAIT_READ exit. Go to WAIT_READ.
- WAIT_READ: same one-cycle blanking as WAIT_CALC. On `sdft_ready` high, register the core bin outputs and the index into the output registers and go to PRESENT.
- PRESENT: hold `bin_valid` and the data stable until accepted. On accept:
  - If the index is `freq_bins`-1: pulse `scan_done`, clear `scan_pending` and the scan-active flag, reset the index to 0, go to IDLE.
  - Otherwise increment the index. If `full`, go to START (sample interleave); else go to READ.
- Scans are not snapshots. Interleaved updates can land between bin reads; consumers accept this.
- If `scan_pending` is set again while a scan is active, it is merged into the current scan (no queue).

## Timing
- Reset values: all outputs 0, state IDLE, `full` 0, counters 0.
- Reset mid-operation: the core has no reset. After reset, IDLE issues nothing until `sdft_ready` is high, which naturally waits out an in-flight core update.
- Latency from capture to `sdft_start`: 1 cycle when IDLE and the core is ready (capture at edge N, start high in cycle N+1).
- `sdft_start` and `sdft_read` are never high together, and never high while `sdft_ready` is low.
- `bin_valid` rises 1 cycle after `sdft_ready` returns in WAIT_READ.
- A sample and `bin_accept` in the same cycle are both honoured.

## Structure
- Package `sdft_pkg`: state enum, `bin_addr_w` = $clog2(freq_bins), default widths.
- Sub-module `sdft_sample_buffer`: the one-entry holding register with the full/overrun logic.
- The FSM, counters and output registers live in `sdft_scheduler`.

## Test plan
- Idle core (ready model: low for 50 cycles after start, 2 after read). Sample 5 → `sdft_start` 1 cycle later, `sdft_sample`=5 held until ready returns. `busy` returns to 0.
- With `scan_divider`=4, feed 4 samples spaced 100 cycles → one scan. Bins 0..15 are presented in order with the model's values. `scan_done` pulses once after bin 15 is accepted.
- Mid-scan sample arrival: the start is issued between bin k and bin k+1, the scan resumes at k+1, and no bin is skipped or repeated.
- Two samples during one busy update → `overrun`=1. The first sample is delivered, the second is dropped. `overrun_clear` returns the flag to 0.
- Consumer holds `bin_accept` low for 20 cycles → data is stable throughout and no reads are issued.
- Reset asserted in WAIT_CALC with core ready low → no start or read is issued until ready rises; the next sample then proceeds normally.

Source files
------------

// File: rtl/sdft_pkg.sv
// Shared types and defaults for the sliding-DFT sequencer.
package sdft_pkg;

  localparam int default_data_width = 8;
  localparam int default_freq_bins  = 16;
  localparam int default_bin_width  = 23;
  localparam int bin_addr_w         = $clog2(default_freq_bins);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_CALC,
    READ,
    WAIT_READ,
    PRESENT
  } state_t;

  // True when one more accepted sample completes a scan interval.
  function automatic logic count_wraps(input logic [7:0] count, input logic [7:0] divider);
    return ({1'b0, count} + 9'd1) >= {1'b0, divider};
  endfunction

endpackage

// File: rtl/sdft_sample_buffer.sv
// One-entry sample holding register with sticky overrun detection.
module sdft_sample_buffer #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  consume,
  input  logic                  overrun_clear,
  output logic [data_width-1:0] held,
  output logic                  full,
  output logic                  overrun
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held    <= '0;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A capture in the cycle the held sample is consumed refills the entry.
      if (sample_valid && (!full || consume)) begin
        held <= sample_in;
        full <= 1'b1;
      end else if (consume) begin
        full <= 1'b0;
      end

      if (sample_valid && full && !consume) begin
        overrun <= 1'b1;
      end else if (overrun_clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdft_scheduler.sv
// Sequences sample updates and periodic bin scans through the sliding-DFT core.
module sdft_scheduler
  import sdft_pkg::*;
#(
  parameter int data_width   = default_data_width,
  parameter int freq_bins    = default_freq_bins,
  parameter int bin_width    = default_bin_width,
  parameter int scan_divider = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [data_width-1:0]        sample_in,
  input  logic                         sample_valid,
  input  logic                         overrun_clear,
  output logic [data_width-1:0]        sdft_sample,
  output logic                         sdft_start,
  output logic                         sdft_read,
  output logic [$clog2(freq_bins)-1:0] sdft_bin_addr,
  input  logic                         sdft_ready,
  input  logic [bin_width-1:0]         sdft_bin_real,
  input  logic [bin_width-1:0]         sdft_bin_imag,
  output logic                         bin_valid,
  input  logic                         bin_accept,
  output logic [$clog2(freq_bins)-1:0] bin_index,
  output logic [bin_width-1:0]         bin_real,
  output logic [bin_width-1:0]         bin_imag,
  output logic                         scan_done,
  output logic                         overrun,
  output logic                         busy
);

  localparam int addr_w = $clog2(freq_bins);
  localparam logic [addr_w-1:0] last_bin = addr_w'(freq_bins - 1);

  state_t              state;
  logic [data_width-1:0] held;
  logic                full;
  logic                consume;
  logic [7:0]          sample_count;
  logic                scan_pending;
  logic                scan_active;
  logic                blank;
  logic [addr_w-1:0]   scan_index;

  assign consume = (state == START);
  assign busy    = (state != IDLE);

  sdft_sample_buffer #(
    .data_width(data_width)
  ) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .consume      (consume),
    .overrun_clear(overrun_clear),
    .held         (held),
    .full         (full),
    .overrun      (overrun)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sdft_sample   <= '0;
      sdft_start    <= 1'b0;
      sdft_read     <= 1'b0;
      sdft_bin_addr <= '0;
      bin_valid     <= 1'b0;
      bin_index     <= '0;
      bin_real      <= '0;
      bin_imag      <= '0;
      scan_done     <= 1'b0;
      sample_count  <= '0;
      scan_pending  <= 1'b0;
      scan_active   <= 1'b0;
      blank         <= 1'b0;
      scan_index    <= '0;
    end else begin
      sdft_start <= 1'b0;
      sdft_read  <= 1'b0;
      scan_done  <= 1'b0;
      blank      <= 1'b0;
      case (state)
        IDLE: begin
          if (full && sdft_ready) begin
            state       <= START;
            sdft_start  <= 1'b1;
            sdft_sample <= held;
          end else if (scan_pending && sdft_ready) begin
            state         <= READ;
            sdft_read     <= 1'b1;
            sdft_bin_addr <= scan_index;
            scan_active   <= 1'b1;
          end
        end
        START: begin
          state <= WAIT_CALC;
          blank <= 1'b1;
          if (count_wraps(sample_count, 8'(scan_divider))) begin
            sample_count <= '0;
            scan_pending <= 1'b1;
          end else begin
            sample_count <= sample_count + 8'd1;
          end
        end
        WAIT_CALC: begin
          // The first cycle may still see the pre-start ready level.
          if (!blank && sdft_ready) begin
            if (scan_active) begin
              state         <= READ;
              sdft_read     <= 1'b1;
              sdft_bin_addr <= scan_index;
            end else begin
              state <= IDLE;
            end
          end
        end
        READ: begin
          state <= WAIT_READ;
          blank <= 1'b1;
        end
        WAIT_READ: begin
          if (!blank && sdft_ready) begin
            bin_real  <= sdft_bin_real;
            bin_imag  <= sdft_bin_imag;
            bin_index <= scan_index;
            bin_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (bin_accept) begin
            bin_valid <= 1'b0;
            if (scan_index == last_bin) begin
              scan_done    <= 1'b1;
              scan_pending <= 1'b0;
              scan_active  <= 1'b0;
              scan_index   <= '0;
              state        <= IDLE;
            end else begin
              scan_index <= scan_index + 1'b1;
              if (full) begin
                state       <= START;
                sdft_start  <= 1'b1;
                sdft_sample <= held;
              end else begin
                state         <= READ;
                sdft_read     <= 1'b1;
                sdft_bin_addr <= scan_index + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
